// File: rtl/uart_tx_sched.sv
// uart_tx_sched: moves words from the TX FIFO (registered read port) to the
// TX serializer. Words with a parity error are dropped, good words go out over
// a valid/ready handshake, and a programmable idle gap follows each frame. A
// flush drains and discards the FIFO. Sticky error and saturating drop status
// are provided for the register block.
module uart_tx_sched #(
    parameter int DW    = 8,
    parameter int GAP_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_enable,
    input  logic             i_flush,
    input  logic [GAP_W-1:0] i_gap_cycles,
    output logic             o_fifo_rd_req,
    input  logic             i_fifo_empty,
    input  logic             i_fifo_valid,
    input  logic [DW-1:0]    i_fifo_data,
    input  logic             i_fifo_parity_error,
    output logic [DW-1:0]    o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    input  logic             i_tx_done,
    output logic             o_busy,
    output logic             o_drop_pulse,
    output logic [CNT_W-1:0] o_drop_cnt,
    output logic             o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_DONE,
        S_GAP,
        S_FLUSH
    } state_e;

    state_e           state_q;
    logic [DW-1:0]    tx_data_q;
    logic             tx_valid_q;
    logic             drop_pulse_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;
    logic             err_q;
    logic [GAP_W-1:0] gap_q;
    logic             wait_q;     // second WAIT cycle without data
    logic             rd_pend_q;  // a read was issued last cycle
    logic             rd_req;

    // Read request is a decode of the state, gated so the FIFO is never
    // popped while empty.
    assign rd_req = ((state_q == S_FETCH) || (state_q == S_FLUSH)) && !i_fifo_empty;

    // Saturating increment of the drop counter; it never wraps.
    assign drop_cnt_d = (drop_cnt_q == {CNT_W{1'b1}}) ? drop_cnt_q
                                                      : drop_cnt_q + CNT_W'(1);

    // Scheduler FSM with registered handshake and status outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= S_IDLE;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
            err_q        <= 1'b0;
            gap_q        <= '0;
            wait_q       <= 1'b0;
            rd_pend_q    <= 1'b0;
        end else begin
            drop_pulse_q <= 1'b0;
            rd_pend_q    <= rd_req;
            case (state_q)
                S_IDLE: begin
                    if (i_flush) begin
                        state_q <= S_FLUSH;
                    end else if (i_enable && !i_fifo_empty) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    wait_q  <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_fifo_valid) begin
                        if (i_fifo_parity_error) begin
                            drop_pulse_q <= 1'b1;
                            drop_cnt_q   <= drop_cnt_d;
                            state_q      <= S_IDLE;
                        end else begin
                            tx_data_q  <= i_fifo_data;
                            tx_valid_q <= 1'b1;
                            state_q    <= S_SEND;
                        end
                    end else if (wait_q) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wait_q <= 1'b1;
                    end
                end
                S_SEND: begin
                    // Valid stays up with stable data until the serializer takes it.
                    if (i_tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_tx_done) begin
                        if (i_gap_cycles == '0) begin
                            state_q <= S_IDLE;
                        end else begin
                            gap_q   <= i_gap_cycles;
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q <= GAP_W'(1)) begin
                        gap_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (i_fifo_valid) begin
                        drop_pulse_q <= 1'b1;
                        drop_cnt_q   <= drop_cnt_d;
                    end
                    // Leave only once no read is still in flight.
                    if (!i_flush && i_fifo_empty && !rd_pend_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_fifo_rd_req = rd_req;
    assign o_tx_data     = tx_data_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_drop_pulse  = drop_pulse_q;
    assign o_drop_cnt    = drop_cnt_q;
    assign o_err         = err_q;

`ifndef SYNTHESIS
    a_valid_hold: assert property (@(posedge i_clk) disable iff (!i_nrst)
        (o_tx_valid && !i_tx_ready) |=> (o_tx_valid && $stable(o_tx_data)));
    a_no_empty_read: assert property (@(posedge i_clk) disable iff (!i_nrst)
        o_fifo_rd_req |-> !i_fifo_empty);
    a_no_x: assert property (@(posedge i_clk) disable iff (!i_nrst)
        !$isunknown({o_tx_valid, o_fifo_rd_req}));
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural FIFO (registered read
// port) and a second instance using a 2-bit drop counter for saturation.
module tb_uart_tx_sched;

    logic       i_clk = 1'b0;
    logic       i_nrst = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_flush = 1'b0;
    logic [7:0] i_gap_cycles = 8'd0;
    logic       i_tx_ready = 1'b0;
    logic       i_tx_done = 1'b0;

    logic       o_fifo_rd_req, o_tx_valid, o_busy, o_drop_pulse, o_err;
    logic [7:0] o_tx_data, o_drop_cnt;
    logic       rd_req2, tx_valid2, busy2, drop_pulse2, err2;
    logic [7:0] tx_data2;
    logic [1:0] drop_cnt2;

    // FIFO model: words written by the stimulus, read pointer owned by the model
    logic [7:0] words [64];
    logic       perrs [64];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       stub_dead = 1'b0;
    logic       fifo_valid = 1'b0;
    logic [7:0] fifo_data = 8'd0;
    logic       fifo_perr = 1'b0;
    logic       fifo_empty;
    assign fifo_empty = (wr_ptr == rd_ptr);

    // Event counters from the primary instance
    int n_rd = 0, n_tx = 0, n_drop = 0, n_vcyc = 0;
    logic [7:0] last_tx = 8'd0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 i_clk = ~i_clk;

    uart_tx_sched #(.DW(8), .GAP_W(8), .CNT_W(8)) u_dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_enable(i_enable), .i_flush(i_flush),
        .i_gap_cycles(i_gap_cycles), .o_fifo_rd_req(o_fifo_rd_req),
        .i_fifo_empty(fifo_empty), .i_fifo_valid(fifo_valid), .i_fifo_data(fifo_data),
        .i_fifo_parity_error(fifo_perr), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
        .i_tx_ready(i_tx_ready), .i_tx_done(i_tx_done), .o_busy(o_busy),
        .o_drop_pulse(o_drop_pulse), .o_drop_cnt(o_drop_cnt), .o_err(o_err)
    );

    uart_tx_sched #(.DW(8), .GAP_W(8), .CNT_W(2)) u_dut_sat (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_enable(i_enable), .i_flush(i_flush),
        .i_gap_cycles(i_gap_cycles), .o_fifo_rd_req(rd_req2),
        .i_fifo_empty(fifo_empty), .i_fifo_valid(fifo_valid), .i_fifo_data(fifo_data),
        .i_fifo_parity_error(fifo_perr), .o_tx_data(tx_data2), .o_tx_valid(tx_valid2),
        .i_tx_ready(i_tx_ready), .i_tx_done(i_tx_done), .o_busy(busy2),
        .o_drop_pulse(drop_pulse2), .o_drop_cnt(drop_cnt2), .o_err(err2)
    );

    // Registered FIFO read port: data and valid one cycle after the request
    always @(posedge i_clk) begin
        fifo_valid <= 1'b0;
        if (o_fifo_rd_req && !fifo_empty) begin
            fifo_data  <= words[rd_ptr % 64];
            fifo_perr  <= perrs[rd_ptr % 64];
            fifo_valid <= !stub_dead;
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // Observe traffic of the primary instance
    always @(posedge i_clk) begin
        if (o_fifo_rd_req) n_rd <= n_rd + 1;
        if (o_drop_pulse) n_drop <= n_drop + 1;
        if (o_tx_valid) n_vcyc <= n_vcyc + 1;
        if (o_tx_valid && i_tx_ready) begin
            n_tx    <= n_tx + 1;
            last_tx <= o_tx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic push(input logic [7:0] d, input logic pe);
        words[wr_ptr % 64] = d;
        perrs[wr_ptr % 64] = pe;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 30 && !o_tx_valid; k++) tick();
        check({tag, "_valid_seen"}, o_tx_valid, 1);
    endtask

    task automatic pulse_done();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    int rd0, tx0, dr0, vc0, k, gap_busy;

    initial begin
        // Reset state
        tick();
        check("rst_busy", o_busy, 0);
        check("rst_tx_valid", o_tx_valid, 0);
        check("rst_rd_req", o_fifo_rd_req, 0);
        check("rst_drop_cnt", o_drop_cnt, 0);
        check("rst_drop_pulse", o_drop_pulse, 0);
        check("rst_err", o_err, 0);
        check("rst_tx_data", o_tx_data, 0);
        i_nrst = 1'b1;
        tick();

        // 1: single good word 0xA5, ready high, no gap
        i_tx_ready = 1'b1;
        tx0 = n_tx;
        push(8'hA5, 1'b0);
        i_enable = 1'b1;
        tick();
        check("t1_rd_req", o_fifo_rd_req, 1);
        tick();
        check("t1_rd_once", o_fifo_rd_req, 0);
        check("t1_valid_not_yet", o_tx_valid, 0);
        tick();
        check("t1_valid", o_tx_valid, 1);
        check("t1_data", o_tx_data, 8'hA5);
        tick();
        check("t1_valid_drop", o_tx_valid, 0);
        check("t1_busy_done", o_busy, 1);
        pulse_done();
        check("t1_idle", o_busy, 0);
        check("t1_drop_cnt", o_drop_cnt, 0);
        check("t1_frames", n_tx - tx0, 1);

        // 2: ready low for 5 cycles, data must hold
        i_tx_ready = 1'b0;
        tx0 = n_tx;
        push(8'h3C, 1'b0);
        wait_valid("t2");
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", o_tx_valid, 1);
            check("t2_hold_data", o_tx_data, 8'h3C);
            tick();
        end
        check("t2_no_early_accept", n_tx - tx0, 0);
        i_tx_ready = 1'b1;
        tick();
        check("t2_valid_drop", o_tx_valid, 0);
        check("t2_frames", n_tx - tx0, 1);
        check("t2_last", last_tx, 8'h3C);
        pulse_done();

        // 3: parity-error word dropped, next word sent
        tx0 = n_tx;
        dr0 = n_drop;
        push(8'h11, 1'b1);
        push(8'h22, 1'b0);
        wait_valid("t3");
        check("t3_data", o_tx_data, 8'h22);
        check("t3_drop_cnt", o_drop_cnt, 1);
        check("t3_drop_pulses", n_drop - dr0, 1);
        tick();
        check("t3_frames", n_tx - tx0, 1);
        check("t3_last", last_tx, 8'h22);
        pulse_done();

        // 4: gap of 4 cycles between done and the next read
        i_gap_cycles = 8'd4;
        push(8'h55, 1'b0);
        push(8'h66, 1'b0);
        wait_valid("t4a");
        check("t4_data1", o_tx_data, 8'h55);
        tick();
        pulse_done();
        i_gap_cycles = 8'd1;  // must not affect the running gap
        k = 0;
        gap_busy = 0;
        while (!o_fifo_rd_req && k < 20) begin
            if (o_busy) gap_busy++;
            k++;
            tick();
        end
        check("t4_gap_cycles", gap_busy, 4);
        check("t4_done_to_rd", k, 5);
        i_gap_cycles = 8'd0;
        wait_valid("t4b");
        check("t4_data2", o_tx_data, 8'h66);
        tick();
        pulse_done();
        check("t4_idle", o_busy, 0);

        // 5: flush 3 words with a 1-cycle pulse, enable low
        i_enable = 1'b0;
        rd0 = n_rd; tx0 = n_tx; dr0 = n_drop; vc0 = n_vcyc;
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'h03, 1'b0);
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("t5_flush_busy", o_busy, 1);
        for (k = 0; k < 30 && o_busy; k++) tick();
        check("t5_returned_idle", o_busy, 0);
        check("t5_rd_count", n_rd - rd0, 3);
        check("t5_drop_pulses", n_drop - dr0, 3);
        check("t5_drop_cnt", o_drop_cnt, 4);
        check("t5_no_tx", n_tx - tx0, 0);
        check("t5_no_valid", n_vcyc - vc0, 0);
        check("t5_empty", fifo_empty, 1);
        check("t5_sat_cnt", drop_cnt2, 3);

        // 5b: flush priority over enable, 5 more words; 2-bit counter stays at 3
        rd0 = n_rd; tx0 = n_tx;
        for (int i = 0; i < 5; i++) push(8'h80 + 8'(i), 1'b0);
        i_enable = 1'b1;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        tick();
        for (k = 0; k < 30 && o_busy; k++) tick();
        check("t5b_rd_count", n_rd - rd0, 5);
        check("t5b_no_tx", n_tx - tx0, 0);
        check("t5b_drop_cnt", o_drop_cnt, 9);
        check("t5b_sat_cnt", drop_cnt2, 3);
        i_enable = 1'b0;
        tick();

        // 6a: FIFO never answers -> sticky error after 2 WAIT cycles
        stub_dead = 1'b1;
        push(8'h77, 1'b0);
        i_enable = 1'b1;
        for (k = 0; k < 10 && !o_fifo_rd_req; k++) tick();
        check("t6_rd_req", o_fifo_rd_req, 1);
        tick();
        check("t6_wait1_err", o_err, 0);
        tick();
        check("t6_wait2_err", o_err, 0);
        check("t6_wait2_busy", o_busy, 1);
        tick();
        check("t6_err", o_err, 1);
        check("t6_idle", o_busy, 0);
        tick();
        check("t6_err_sticky", o_err, 1);
        stub_dead = 1'b0;

        // 6b: asynchronous reset during SEND
        i_tx_ready = 1'b0;
        push(8'h99, 1'b0);
        wait_valid("t6b");
        i_nrst = 1'b0;
        #1;
        check("t6b_valid", o_tx_valid, 0);
        check("t6b_rd_req", o_fifo_rd_req, 0);
        check("t6b_busy", o_busy, 0);
        check("t6b_err", o_err, 0);
        check("t6b_drop_cnt", o_drop_cnt, 0);
        check("t6b_sat_cnt", drop_cnt2, 0);
        i_enable = 1'b0;
        tick();
        i_nrst = 1'b1;
        tick();
        check("t6b_idle_after", o_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
